// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Oversampling geometry and baud divider helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int OVERSAMPLE = 16;

  localparam logic [3:0] SAMPLE_A = 4'd7;
  localparam logic [3:0] SAMPLE_B = 4'd8;
  localparam logic [3:0] SAMPLE_C = 4'd9;

  function automatic int unsigned calc_div(
    input int unsigned clk_hz,
    input int unsigned baud,
    input int unsigned os
  );
    return clk_hz / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator.
// One-cycle pulse every CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks.
module uart_baud_tick #(
  parameter logic [27:0] CLOCK_FREQ = 28'd100000000,
  parameter logic [23:0] BAUD_RATE  = 24'd9600,
  parameter int          OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [27:0] DIV = 28'(uart_pkg::calc_div(
    32'(CLOCK_FREQ), 32'(BAUD_RATE), 32'(OVERSAMPLE)));

  generate
    if (DIV < 28'd2) begin : g_div_chk
      $error("uart_baud_tick: divider must be at least 2");
    end
  endgenerate

  logic [27:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == DIV - 28'd1) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 28'd1;
    end
  end

  assign tick = (cnt == DIV - 28'd1);

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver, 16x oversampled with 3-sample majority vote,
// feeding a small valid/ready receive FIFO with sticky error flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter logic [23:0] BAUD_RATE  = 24'd9600,
  parameter logic [27:0] CLOCK_FREQ = 28'd100000000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                          clk_10ns,
  input  logic                          uart_reset,
  input  logic                          uart_rx_d_in,
  output logic [7:0]                    uart_rx_data,
  output logic                          uart_rx_valid,
  input  logic                          uart_rx_ready,
  input  logic                          uart_err_clear,
  output logic                          uart_frame_err,
  output logic                          uart_overrun,
  output logic                          uart_rx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   uart_fifo_count
);

  localparam int          AW   = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

  generate
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
      $error("uart_rx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic [1:0] sync;
  logic       rxs;

  always_ff @(posedge clk_10ns or negedge uart_reset) begin
    if (!uart_reset) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], uart_rx_d_in};
    end
  end

  assign rxs = sync[1];

  logic tick;

  uart_baud_tick #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clk   (clk_10ns),
    .rst_n (uart_reset),
    .tick  (tick)
  );

  rx_state_t  state, state_n;
  logic [3:0] sc, sc_n, sc_inc;
  logic [2:0] idx, idx_n;
  logic [1:0] smp, smp_n;
  logic [7:0] sh, sh_n;
  logic       maj;
  logic       push_n, push_q;
  logic       ferr_set;

  assign sc_inc = sc + 4'd1;
  assign maj    = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);

  // sc counts the sample index the current tick represents
  always_comb begin
    state_n  = state;
    sc_n     = sc;
    idx_n    = idx;
    smp_n    = smp;
    sh_n     = sh;
    push_n   = 1'b0;
    ferr_set = 1'b0;
    if (tick) begin
      if (state == IDLE) begin
        if (!rxs) begin
          state_n = START;
          sc_n    = 4'd0;
        end
      end else begin
        sc_n = sc_inc;
        if (sc_inc == SAMPLE_A) smp_n[0] = rxs;
        if (sc_inc == SAMPLE_B) smp_n[1] = rxs;
        unique case (state)
          START: begin
            if (sc_inc == SAMPLE_C && maj) begin
              state_n = IDLE;
            end else if (sc_inc == 4'd15) begin
              state_n = DATA;
              idx_n   = 3'd0;
            end
          end
          DATA: begin
            if (sc_inc == SAMPLE_C) sh_n[idx] = maj;
            if (sc_inc == 4'd15) begin
              idx_n = idx + 3'd1;
              if (idx == 3'd7) state_n = STOP;
            end
          end
          STOP: begin
            if (sc_inc == SAMPLE_C) begin
              state_n  = IDLE;
              push_n   = maj;
              ferr_set = ~maj;
            end
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_10ns or negedge uart_reset) begin
    if (!uart_reset) begin
      state  <= IDLE;
      sc     <= '0;
      idx    <= '0;
      smp    <= '0;
      sh     <= '0;
      push_q <= 1'b0;
    end else begin
      state  <= state_n;
      sc     <= sc_n;
      idx    <= idx_n;
      smp    <= smp_n;
      sh     <= sh_n;
      push_q <= push_n;
    end
  end

  assign uart_rx_busy = (state != IDLE);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          pop, full, wr_ok, ovr_set;

  assign pop     = uart_rx_valid & uart_rx_ready;
  assign full    = (count == FULL);
  assign wr_ok   = push_q & (~full | pop);
  assign ovr_set = push_q & full & ~pop;

  always_ff @(posedge clk_10ns) begin
    if (wr_ok) mem[wptr] <= sh;
  end

  always_ff @(posedge clk_10ns or negedge uart_reset) begin
    if (!uart_reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      unique case (1'b1)
        wr_ok & ~pop: count <= count + 1'b1;
        pop & ~wr_ok: count <= count - 1'b1;
        default:      count <= count;
      endcase
    end
  end

  assign uart_rx_valid   = (count != '0);
  assign uart_rx_data    = uart_rx_valid ? mem[rptr] : 8'h00;
  assign uart_fifo_count = count;

  // a set in the same cycle as a clear keeps the flag high
  always_ff @(posedge clk_10ns or negedge uart_reset) begin
    if (!uart_reset) begin
      uart_frame_err <= 1'b0;
      uart_overrun   <= 1'b0;
    end else begin
      uart_frame_err <= ferr_set | (uart_frame_err & ~uart_err_clear);
      uart_overrun   <= ovr_set | (uart_overrun & ~uart_err_clear);
    end
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Standalone 8N1 UART receiver with 16x oversampling, majority-vote bit sampling and a small receive FIFO. It is the receive-side counterpart of our UART transmit path: it terminates the serial line driven by a peer transmitter and presents received bytes on a valid/ready interface. Line errors are reported as sticky flags. It sits beside the transmitter under the Tiny Tapeout top level and replaces the single-byte holding register receive path.

## Interface
- BAUD_RATE, 24'd9600, serial bit rate
- CLOCK_FREQ, 28'd100000000, clk_10ns frequency in Hz
- FIFO_DEPTH, 4, receive FIFO entries; power of two, at least 2
- clk_10ns  in  1  single system clock; all logic is on its rising edge
- uart_reset  in  1  asynchronous, active-low reset
- uart_rx_d_in  in  1  serial line, idle high, asynchronous to clk_10ns
- uart_rx_data  out  8  FIFO head byte; valid only while uart_rx_valid=1
- uart_rx_valid  out  1  FIFO not empty
- uart_rx_ready  in  1  consumer accepts the head byte
- uart_err_clear  in  1  one-cycle pulse that clears both sticky flags
- uart_frame_err  out  1  sticky: a frame had stop bit = 0
- uart_overrun  out  1  sticky: a good byte was dropped because the FIFO was full
- uart_rx_busy  out  1  FSM not in IDLE
- uart_fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy

## Operation
- Synchroniser: 2-FF on uart_rx_d_in, reset to 1. The FSM sees only the synchronised value rxs.
- Tick: free-running, asserted for one cycle every DIV = CLOCK_FREQ/(BAUD_RATE*16) cycles. DIV uses integer truncation and is checked at elaboration to be ≥ 2. A 28-bit counter runs 0..DIV-1 and the tick fires at DIV-1.
- Sample counter sc is 4 bits, advances on each tick and wraps 15→0. Samples at sc = 7, 8 and 9 are stored. The bit value is the majority of the three and is resolved at sc = 9.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a tick with rxs=0, go to START with sc=0.
  - START: if the resolved value is 1, it was a false start; return to IDLE with no flag. Otherwise, at sc=15, go to DATA with bit index 0.
  - DATA: shift the resolved bit into bit[idx], LSB first. At sc=15, increment idx. After idx 7, go to STOP.
  - STOP: at sc=9 (resolution), return to IDLE immediately so back-to-back frames are caught. If the stop bit resolved 1, push the byte. If it resolved 0, discard the byte and set uart_frame_err.
- FIFO: push is accepted when count < FIFO_DEPTH, or when a pop occurs in the same cycle. Otherwise the byte is dropped and uart_overrun is set.
  - Pop happens when uart_rx_valid & uart_rx_ready.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
- Sticky flags: a set event in the same cycle as uart_err_clear wins, so the flag stays 1.

## Timing
- Reset values: uart_rx_data=0, uart_rx_valid=0, uart_frame_err=0, uart_overrun=0, uart_rx_busy=0, uart_fifo_count=0. FSM is in IDLE, tick counter=0, synchroniser=1.
- Reset asserted mid-frame aborts the frame. After release the FSM is in IDLE and no partial byte is ever pushed.
- Push happens on the clock edge after the STOP resolution tick. uart_rx_valid and the new count are visible the cycle after the push.
- Latency from the line falling edge to uart_rx_valid is within [9.5625, 9.625] bit times + 3 cycles. The bounds come from 2 synchroniser cycles + up to 1 tick of phase + the push register.
- uart_rx_data is combinational from the FIFO head; no read latency. A pop takes effect at the edge where valid & ready are both high.
- uart_rx_busy is high from the cycle after START entry through the cycle of the STOP resolution.

## Structure
- Package uart_pkg holds:
  - rx_state_t enum {IDLE, START, DATA, STOP}
  - localparam OVERSAMPLE = 16
  - sample indices SAMPLE_A/B/C = 7/8/9
  - the DIV computation function
- Sub-module uart_baud_tick (params CLOCK_FREQ, BAUD_RATE, OVERSAMPLE; outputs tick).
- FIFO is inline: register array plus pointers.

## Test plan
Bench parameters: CLOCK_FREQ=1_600_000, BAUD_RATE=10_000, giving DIV=10 and 160 cycles per bit.
- Single frame 0xA5, ready=1 → exactly one valid beat with data 0xA5; both flags stay 0; busy returns to 0.
- 40-cycle (< ½ bit) low glitch on an idle line → no push, flags 0, FSM back in IDLE within 1 bit time.
- Frame 0x3C with stop bit = 0 → no push, frame_err=1. Then a good frame 0x11 → pushed and frame_err stays 1. err_clear pulse → frame_err=0.
- Five back-to-back frames 0x01..0x05 with ready=0 → count=4, overrun=1. Then drain with ready=1 → output 0x01,0x02,0x03,0x04, then valid=0.
- FIFO full with ready held high so the pop coincides with push of 0x66 → count stays 4, overrun=0, 0x66 delivered last.
- Reset asserted during the DATA bit 3 of a frame, released, then frame 0x5A sent → only 0x5A is delivered; all outputs were at reset values while reset was held.
